// File: rtl/pt_check.sv
// Printable-plaintext checker: snoops the PRGA plaintext write port and decides
// whether the length-prefixed message (addr 0 = L, addrs 1..L = bytes) is all in [LO,HI].
module pt_check #(
    parameter logic [7:0] LO = 8'h20,
    parameter logic [7:0] HI = 8'h7E
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic       rdy_o,
    input  logic [7:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    input  logic       wr_en_i,
    output logic       done_o,
    output logic       key_ok_o,
    output logic       abort_o,
    output logic [7:0] count_o
);

    typedef enum logic [1:0] {IDLE, WAIT_LEN, CHECK, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] count_q, count_d;
    logic       done_q, done_d;
    logic       key_ok_q, key_ok_d;
    logic       abort_q, abort_d;
    logic       in_range;

    assign in_range = (wr_data_i >= LO) && (wr_data_i <= HI);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            len_q    <= 8'd0;
            idx_q    <= 8'd0;
            count_q  <= 8'd0;
            done_q   <= 1'b0;
            key_ok_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            done_q   <= done_d;
            key_ok_q <= key_ok_d;
            abort_q  <= abort_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        count_d  = count_q;
        done_d   = done_q;
        key_ok_d = key_ok_q;
        abort_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (en_i) begin
                    state_d  = WAIT_LEN;
                    done_d   = 1'b0;
                    key_ok_d = 1'b0;
                    count_d  = 8'd0;
                end
            end
            WAIT_LEN: begin
                if (wr_en_i && wr_addr_i == 8'd0) begin
                    len_d = wr_data_i;
                    if (wr_data_i == 8'd0) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        key_ok_d = 1'b1;
                    end else begin
                        state_d = CHECK;
                        idx_d   = 8'd1;
                    end
                end
            end
            CHECK: begin
                // idx starts at 1, so a rewrite of address 0 never matches here
                if (wr_en_i && wr_addr_i == idx_q) begin
                    if (in_range) begin
                        count_d = count_q + 8'd1;
                        if (idx_q == len_q) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            key_ok_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 8'd1;
                        end
                    end else begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        key_ok_d = 1'b0;
                        abort_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rdy_o    = (state_q == IDLE) || (state_q == DONE);
    assign done_o   = done_q;
    assign key_ok_o = key_ok_q;
    assign abort_o  = abort_q;
    assign count_o  = count_q;

endmodule

// File: tb/tb_pt_check.sv
// Scoreboard bench for pt_check: stimulus queues the expected verdict for each check,
// a negedge monitor pops it whenever done rises and polices abort between verdicts.
module tb_pt_check;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       rdy;
    logic [7:0] wr_addr = 8'd0;
    logic [7:0] wr_data = 8'd0;
    logic       wr_en = 1'b0;
    logic       done, key_ok, abort;
    logic [7:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       key_ok;
        logic [7:0] count;
        logic       abort;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic done_prev = 1'b0;

    pt_check dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .rdy_o(rdy),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_en_i(wr_en),
        .done_o(done), .key_ok_o(key_ok), .abort_o(abort), .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        en = 1'b1;
        cyc();
        en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic expect_verdict(input logic k, input logic [7:0] c, input logic a);
        exp_t e;
        e.key_ok = k; e.count = c; e.abort = a;
        sb.push_back(e);
    endtask

    // Monitor: verdict on done rising edge, otherwise abort must stay low.
    always @(negedge clk) begin
        if (!rst && done && !done_prev) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1, expected no verdict at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("verdict_key_ok", {7'd0, key_ok}, {7'd0, mon_e.key_ok});
                chk("verdict_count", count, mon_e.count);
                chk("verdict_abort", {7'd0, abort}, {7'd0, mon_e.abort});
            end
        end else begin
            chk("abort_quiet", {7'd0, abort}, 8'd0);
        end
        done_prev = done;
    end

    initial begin
        // Reset
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        chk("rst_rdy", {7'd0, rdy}, 8'd1);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_key_ok", {7'd0, key_ok}, 8'd0);
        chk("rst_abort", {7'd0, abort}, 8'd0);
        chk("rst_count", count, 8'd0);

        // Good message "Hi!"
        expect_verdict(1'b1, 8'd3, 1'b0);
        start();
        chk("wait_len_rdy", {7'd0, rdy}, 8'd0);
        wr(8'd0, 8'd3); wr(8'd1, 8'h48); wr(8'd2, 8'h69); wr(8'd3, 8'h21);
        repeat (2) cyc();
        chk("good_hold_done", {7'd0, done}, 8'd1);
        chk("good_hold_key_ok", {7'd0, key_ok}, 8'd1);
        chk("good_hold_rdy", {7'd0, rdy}, 8'd1);

        // Bad byte 0x1F; a later write must not disturb the verdict
        expect_verdict(1'b0, 8'd1, 1'b1);
        start();
        chk("restart_clears_done", {7'd0, done}, 8'd0);
        wr(8'd0, 8'd4); wr(8'd1, 8'h41); wr(8'd2, 8'h1F);
        wr(8'd3, 8'h41);
        cyc();
        chk("bad_hold_done", {7'd0, done}, 8'd1);
        chk("bad_hold_key_ok", {7'd0, key_ok}, 8'd0);
        chk("bad_hold_count", count, 8'd1);

        // Boundaries: 0x20 and 0x7E accepted, 0x7F rejected, L=0 immediate pass
        expect_verdict(1'b1, 8'd2, 1'b0);
        start(); wr(8'd0, 8'd2); wr(8'd1, 8'h20); wr(8'd2, 8'h7E); cyc();
        expect_verdict(1'b0, 8'd1, 1'b1);
        start(); wr(8'd0, 8'd2); wr(8'd1, 8'h20); wr(8'd2, 8'h7F); cyc();
        expect_verdict(1'b1, 8'd0, 1'b0);
        start(); wr(8'd0, 8'd0);
        chk("len0_done", {7'd0, done}, 8'd1);
        cyc();

        // Ordering and handshake: out-of-order write and mid-check en ignored
        expect_verdict(1'b1, 8'd2, 1'b0);
        start(); wr(8'd0, 8'd2);
        wr(8'd2, 8'h41);
        chk("ooo_done", {7'd0, done}, 8'd0);
        chk("ooo_count", count, 8'd0);
        start();
        chk("midcheck_en_rdy", {7'd0, rdy}, 8'd0);
        wr(8'd0, 8'd1);
        wr(8'd1, 8'h41);
        chk("inorder_done", {7'd0, done}, 8'd0);
        chk("inorder_count", count, 8'd1);
        wr(8'd2, 8'h41);
        cyc();

        // Reset mid-check, then a normal pass
        start(); wr(8'd0, 8'd5); wr(8'd1, 8'h41); wr(8'd2, 8'h42);
        chk("pre_rst_count", count, 8'd2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_rdy", {7'd0, rdy}, 8'd1);
        chk("midrst_count", count, 8'd0);
        chk("midrst_done", {7'd0, done}, 8'd0);
        chk("midrst_abort", {7'd0, abort}, 8'd0);
        expect_verdict(1'b1, 8'd5, 1'b0);
        start(); wr(8'd0, 8'd5);
        for (int i = 1; i <= 5; i++) wr(8'(i), 8'(8'h40 + i));
        repeat (3) cyc();

        chk("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
